// File: rtl/periodic_frame_gate.sv
// rtl/periodic_frame_gate.sv - trigger-aligned frame scheduler between the detector and the FFT
module periodic_frame_gate #(
    parameter int         WIDTH         = 32,
    parameter int         CNT_W         = 16,
    parameter logic [7:0] SR_FRAME_LEN  = 8'h10,
    parameter logic [7:0] SR_GAP_LEN    = 8'h11,
    parameter logic [7:0] SR_OFFSET     = 8'h12,
    parameter logic [7:0] SR_MAX_FRAMES = 8'h13,
    parameter logic [7:0] SR_CLEAR      = 8'h14
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_ttrig,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frame_idx
);

    typedef enum logic [1:0] {IDLE, OFFSET, FRAME, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [CNT_W-1:0] frame_len_q, gap_len_q, offset_q, max_frames_q;
    logic [CNT_W-1:0] sh_frame_len_q, sh_gap_len_q, sh_max_frames_q;
    logic [CNT_W-1:0] cur_len, cur_gap, cur_max, frame_pos;
    logic             clear, trig_pass, pass, beat, frame_last, latch;
    logic             unused_set_data;

    assign unused_set_data = ^set_data;
    assign clear = set_stb && (set_addr == SR_CLEAR);

    // In IDLE a zero-offset trigger is framed with the live registers, since the
    // shadows only capture them at this very beat.
    assign cur_len   = (state_q == IDLE) ? frame_len_q  : sh_frame_len_q;
    assign cur_gap   = (state_q == IDLE) ? gap_len_q    : sh_gap_len_q;
    assign cur_max   = (state_q == IDLE) ? max_frames_q : sh_max_frames_q;
    assign frame_pos = (state_q == IDLE) ? '0 : cnt_q;

    assign trig_pass  = (state_q == IDLE) && i_tvalid && i_ttrig && !clear && (offset_q == '0);
    assign pass       = (state_q == FRAME) || trig_pass;
    assign frame_last = (cur_len == '0) ? 1'b1 : (frame_pos == cur_len - CNT_W'(1));

    assign o_tdata     = i_tdata;
    assign o_tvalid    = pass && i_tvalid;
    assign o_tlast     = pass && frame_last;
    assign i_tready    = pass ? o_tready : 1'b1;
    assign beat        = i_tvalid && i_tready;
    assign o_busy      = (state_q != IDLE);
    assign o_frame_idx = fidx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fidx_d  = fidx_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat && i_ttrig && !clear) begin
                    latch = 1'b1;
                    if (offset_q == CNT_W'(1)) begin
                        state_d = FRAME;
                        cnt_d   = '0;
                    end else if (offset_q != '0) begin
                        state_d = OFFSET;
                        cnt_d   = offset_q - CNT_W'(1);
                    end
                end
            end
            OFFSET: begin
                if (beat) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (beat) begin
                    if (cnt_q == '0) state_d = FRAME;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (pass && beat) begin
            if (frame_last) begin
                cnt_d = '0;
                if ((cur_max != '0) && (fidx_q + CNT_W'(1) == cur_max)) begin
                    state_d = IDLE;
                    fidx_d  = '0;
                end else begin
                    fidx_d = fidx_q + CNT_W'(1);
                    if (cur_gap == '0) begin
                        state_d = FRAME;
                    end else begin
                        state_d = GAP;
                        cnt_d   = cur_gap - CNT_W'(1);
                    end
                end
            end else begin
                state_d = FRAME;
                cnt_d   = frame_pos + CNT_W'(1);
            end
        end

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            fidx_d  = '0;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            fidx_q          <= '0;
            frame_len_q     <= CNT_W'(64);
            gap_len_q       <= CNT_W'(16);
            offset_q        <= '0;
            max_frames_q    <= CNT_W'(1);
            sh_frame_len_q  <= CNT_W'(64);
            sh_gap_len_q    <= CNT_W'(16);
            sh_max_frames_q <= CNT_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fidx_q  <= fidx_d;
            if (set_stb) begin
                case (set_addr)
                    SR_FRAME_LEN:  frame_len_q  <= set_data[CNT_W-1:0];
                    SR_GAP_LEN:    gap_len_q    <= set_data[CNT_W-1:0];
                    SR_OFFSET:     offset_q     <= set_data[CNT_W-1:0];
                    SR_MAX_FRAMES: max_frames_q <= set_data[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (latch || trig_pass && beat) begin
                sh_frame_len_q  <= frame_len_q;
                sh_gap_len_q    <= gap_len_q;
                sh_max_frames_q <= max_frames_q;
            end
        end
    end

endmodule

// File: tb/tb_periodic_frame_gate.sv
// tb/tb_periodic_frame_gate.sv - randomized bench for periodic_frame_gate against a frame-schedule model
module tb_periodic_frame_gate;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             ce_clk = 1'b0;
    logic             ce_rst_n = 1'b0;
    logic             set_stb = 1'b0;
    logic [7:0]       set_addr = '0;
    logic [31:0]      set_data = '0;
    logic [WIDTH-1:0] i_tdata = '0;
    logic             i_ttrig = 1'b0;
    logic             i_tvalid = 1'b0;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready = 1'b1;
    logic             o_busy;
    logic [CNT_W-1:0] o_frame_idx;

    int errors = 0;
    int checks = 0;
    int got_d[$], got_l[$], exp_d[$], exp_l[$];
    int ref_d[$], ref_l[$];

    periodic_frame_gate dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_ttrig(i_ttrig), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_busy(o_busy), .o_frame_idx(o_frame_idx)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [7:0] addr, input int data);
        @(negedge ce_clk);
        i_tvalid = 1'b0;
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        @(negedge ce_clk);
        set_stb = 1'b0;
    endtask

    task automatic config_all(input int len, input int gap, input int off, input int maxf);
        write_reg(8'h10, len);
        write_reg(8'h11, gap);
        write_reg(8'h12, off);
        write_reg(8'h13, maxf);
    endtask

    // Expected stream: frame k, sample j is input index trig+off+k*(L+gap)+j.
    task automatic model(input int nsamp, input int trig, input int len, input int gap,
                         input int off, input int maxf);
        int l, k, idx;
        l = (len == 0) ? 1 : len;
        exp_d.delete();
        exp_l.delete();
        k = 0;
        while (maxf == 0 || k < maxf) begin
            for (int j = 0; j < l; j++) begin
                idx = trig + off + k * (l + gap) + j;
                if (idx >= nsamp) return;
                exp_d.push_back(idx);
                exp_l.push_back(j == l - 1);
            end
            k++;
        end
    endtask

    task automatic run(input int nsamp, input int trig, input int retrig, input bit stall,
                       input int stop_out, input int midw);
        int ptr, cyc;
        bit wrote;
        got_d.delete();
        got_l.delete();
        ptr   = 0;
        cyc   = 0;
        wrote = 0;
        while (ptr < nsamp && got_d.size() < stop_out && cyc < 20000) begin
            @(negedge ce_clk);
            set_stb = 1'b0;
            if (midw >= 0 && !wrote && got_d.size() == midw) begin
                set_stb  = 1'b1;
                set_addr = 8'h10;
                set_data = 8;
                wrote    = 1;
            end
            i_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            o_tready = stall ? $urandom_range(0, 1) : 1'b1;
            i_tdata  = ptr;
            i_ttrig  = (ptr == trig) || (ptr == retrig);
            #1;
            if (o_tvalid && o_tready) begin
                got_d.push_back(o_tdata);
                got_l.push_back(o_tlast);
            end
            if (i_tvalid && i_tready) ptr++;
            cyc++;
        end
        if (cyc >= 20000) check("cycle_budget", cyc, 0);
        @(negedge ce_clk);
        set_stb  = 1'b0;
        i_tvalid = 1'b0;
        i_ttrig  = 1'b0;
        o_tready = 1'b1;
    endtask

    task automatic compare(input string tag, input bit prefix);
        int n, bad;
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        if (!prefix) check({tag, "_count"}, got_d.size(), exp_d.size());
        bad = 0;
        for (int i = 0; i < n; i++)
            if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) bad++;
        check({tag, "_mismatched_beats"}, bad, 0);
        if (n > 0) check({tag, "_first"}, got_d[0], exp_d[0]);
    endtask

    initial begin
        int nlast;
        #2;
        check("reset_busy", o_busy, 0);
        check("reset_fidx", o_frame_idx, 0);
        check("reset_tvalid", o_tvalid, 0);
        check("reset_itready", i_tready, 1);
        #20;
        @(negedge ce_clk);
        ce_rst_n = 1'b1;

        // Defaults 64/16/0/1
        run(1000, 100, -1, 0, 1 << 30, -1);
        model(1000, 100, 64, 16, 0, 1);
        compare("defaults", 0);
        check("defaults_last_tlast", got_d[got_d.size()-1] * 2 + got_l[got_l.size()-1], 163 * 2 + 1);
        check("defaults_busy_end", o_busy, 0);

        // Twelve-frame schedule, unstalled then stalled
        config_all(64, 16, 29, 12);
        run(1000, 10, -1, 0, 1 << 30, -1);
        model(1000, 10, 64, 16, 29, 12);
        compare("twelve", 0);
        nlast = 0;
        foreach (got_l[i]) nlast += got_l[i];
        check("twelve_tlasts", nlast, 12);
        ref_d = got_d;
        ref_l = got_l;
        run(1000, 10, -1, 1, 1 << 30, -1);
        compare("twelve_stalled", 0);
        check("stalled_equals_unstalled", (got_d == ref_d) && (got_l == ref_l), 1);
        check("twelve_busy_end", o_busy, 0);

        // Back-to-back frames
        config_all(4, 0, 0, 3);
        run(40, 5, -1, 0, 1 << 30, -1);
        model(40, 5, 4, 0, 0, 3);
        compare("b2b", 0);

        // Unlimited frames ended by clear mid-frame
        config_all(64, 16, 0, 0);
        run(1000, 3, -1, 0, 5 * 64 + 10, -1);
        model(1000, 3, 64, 16, 0, 0);
        compare("unlimited", 1);
        check("unlimited_fidx_before_clear", o_frame_idx, 5);
        set_stb  = 1'b1;
        set_addr = 8'h14;
        i_tvalid = 1'b1;
        i_tdata  = 32'h1234;
        @(negedge ce_clk);
        set_stb = 1'b0;
        #1;
        check("clear_tvalid", o_tvalid, 0);
        check("clear_busy", o_busy, 0);
        check("clear_fidx", o_frame_idx, 0);
        write_reg(8'h13, 1);
        run(200, 7, -1, 0, 1 << 30, -1);
        model(200, 7, 64, 16, 0, 1);
        compare("after_clear", 0);

        // Retrigger ignored; mid-burst frame_len write applies to the next burst
        run(200, 50, 80, 1, 1 << 30, 10);
        model(200, 50, 64, 16, 0, 1);
        compare("retrig_shadow", 0);
        run(100, 20, -1, 0, 1 << 30, -1);
        model(100, 20, 8, 16, 0, 1);
        compare("new_len", 0);

        // Asynchronous reset mid-frame, then defaults restored
        run(100, 10, -1, 0, 4, -1);
        i_tvalid = 1'b1;
        i_tdata  = 32'd99;
        #1;
        check("pre_reset_busy", o_busy, 1);
        ce_rst_n = 1'b0;
        #1;
        check("async_reset_tvalid", o_tvalid, 0);
        check("async_reset_busy", o_busy, 0);
        check("async_reset_fidx", o_frame_idx, 0);
        @(negedge ce_clk);
        i_tvalid = 1'b0;
        ce_rst_n = 1'b1;
        run(300, 40, -1, 0, 1 << 30, -1);
        model(300, 40, 64, 16, 0, 1);
        compare("post_reset_defaults", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
